// File: rtl/mic_frame_buffer.sv
// mic_frame_buffer: circular mic sample buffer that captures one frame
// around an impact trigger and replays it over a valid/ready stream.
//
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   data_i/data_en_i signed 8-bit sample and its one-cycle strobe
//   capture_en_i     impact-detect level; its rising edge triggers
//   out_data_o       frame sample, oldest first
//   out_valid_o      out_data_o valid
//   out_ready_i      consumer accepts the sample
//   out_last_o       final sample of the frame
//   busy_o           frame in progress (POST or READ)
module mic_frame_buffer #(
    parameter int FRAME_LEN = 256,
    parameter int ADDR_W    = 8,
    parameter int PRE_LEN   = 32
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] data_i,
    input  logic       data_en_i,
    input  logic       capture_en_i,
    output logic [7:0] out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic       out_last_o,
    output logic       busy_o
);

    localparam int FW = $clog2(PRE_LEN + 1);
    localparam logic [FW-1:0] PRE_MAX = FW'(PRE_LEN);
    localparam logic [ADDR_W:0] FRAME_CNT = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        POST,
        READ
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [7:0] mem [FRAME_LEN];

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] start_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_nxt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [FW-1:0]     fill_cnt;
    logic [ADDR_W:0]   post_rem;
    logic [ADDR_W:0]   post_init;
    logic              cap_q;
    logic              trig;
    logic              wr_en;
    logic              xfer;

    assign trig   = (state_q == IDLE) && capture_en_i && !cap_q;
    assign wr_en  = data_en_i && (state_q != READ);
    assign xfer   = out_valid_o && out_ready_i;
    assign rd_nxt = rd_ptr + ADDR_W'(1);
    assign busy_o = (state_q != IDLE);

    // Post-trigger samples still owed; a sample arriving with the
    // trigger already counts as the first one.
    assign post_init = FRAME_CNT
                     - (ADDR_W + 1)'(fill_cnt)
                     - (ADDR_W + 1)'(data_en_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = (post_init == '0) ? READ : POST;
                end
            end
            POST: begin
                if (data_en_i && post_rem == (ADDR_W + 1)'(1)) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (xfer && out_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample storage carries no reset; only written outside READ.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr      <= '0;
            start_ptr   <= '0;
            rd_ptr      <= '0;
            rd_cnt      <= '0;
            fill_cnt    <= '0;
            post_rem    <= '0;
            cap_q       <= 1'b0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
        end else begin
            // Edge register tracks the level in every state, so a level
            // held across a frame never looks like a new edge.
            cap_q <= capture_en_i;
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (trig) begin
                        start_ptr <= wr_ptr - ADDR_W'(fill_cnt);
                        post_rem  <= post_init;
                    end else if (data_en_i && fill_cnt != PRE_MAX) begin
                        fill_cnt <= fill_cnt + FW'(1);
                    end
                end
                POST: begin
                    if (data_en_i) begin
                        post_rem <= post_rem - (ADDR_W + 1)'(1);
                    end
                end
                READ: begin
                    // Output register doubles as the synchronous RAM read
                    // port; it reloads only when the current word is taken.
                    if (!out_valid_o) begin
                        out_data_o  <= mem[start_ptr];
                        out_valid_o <= 1'b1;
                        out_last_o  <= (LAST_IDX == '0);
                        rd_ptr      <= start_ptr;
                        rd_cnt      <= '0;
                    end else if (out_ready_i) begin
                        if (out_last_o) begin
                            out_valid_o <= 1'b0;
                            out_last_o  <= 1'b0;
                            fill_cnt    <= '0;
                        end else begin
                            out_data_o <= mem[rd_nxt];
                            rd_ptr     <= rd_nxt;
                            rd_cnt     <= rd_cnt + ADDR_W'(1);
                            out_last_o <= (rd_cnt + ADDR_W'(1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
